// File: rtl/trainled_tx.sv
`default_nettype none
// ============================================================================
// Module   : trainled_tx
// Purpose  : Serialises 24-bit LED words into high/data/low bit cells on dout,
//            with a forced-low latch gap after each frame.
// Revision : 1.0  initial release
// ============================================================================
module trainled_tx #(
  parameter int PHASE = 4,
  parameter int GAP   = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int PW = (PHASE > 1) ? $clog2(PHASE) : 1;
  localparam int CW = $clog2(GAP + 1);
  localparam logic [PW-1:0] c_PH_LAST  = PW'(PHASE - 1);
  localparam logic [PW-1:0] c_PH_PRE   = PW'(PHASE - 2);
  localparam logic [CW-1:0] c_GAP_LAST = CW'(GAP);
  localparam logic [CW-1:0] c_GAP_PRE  = CW'(GAP - 1);
  localparam logic [CW-1:0] c_UR_PRE   = CW'(95);

  typedef enum logic [2:0] {
    S_GAP  = 3'd0,
    S_IDLE = 3'd1,
    S_HIGH = 3'd2,
    S_DATA = 3'd3,
    S_LOW  = 3'd4
  } state_t;

  state_t        r_state;
  logic [23:0]   r_sh;
  logic          r_last;
  logic          r_midf;
  logic [PW-1:0] r_ph;
  logic [4:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_under;
  logic          w_xfer;

  assign w_xfer     = s_valid & r_ready;
  assign s_ready    = r_ready;
  assign dout       = r_dout;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign underrun   = r_under;

  // r_cnt numbers GAP / stall cycles from 1, so the reset-release cycle acts as cycle 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_GAP;
      r_sh    <= '0;
      r_last  <= 1'b0;
      r_midf  <= 1'b0;
      r_ph    <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_under <= 1'b0;
      if (w_xfer) begin
        r_sh    <= s_data;
        r_last  <= s_last;
        r_bit   <= 5'd23;
        r_ph    <= '0;
        r_state <= S_HIGH;
        r_dout  <= 1'b1;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
        r_midf  <= 1'b0;
      end else begin
        case (r_state)
          S_GAP: begin
            r_dout <= 1'b0;
            if (r_cnt == c_GAP_LAST) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_midf  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == c_GAP_PRE) r_done <= 1'b1;
            end
          end
          S_IDLE: begin
            r_dout <= 1'b0;
            if (r_midf) begin
              if (r_cnt == c_UR_PRE) begin
                r_under <= 1'b1;
                r_midf  <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          S_HIGH: begin
            if (r_ph == c_PH_LAST) begin
              r_ph    <= '0;
              r_state <= S_DATA;
              r_dout  <= r_sh[23];
            end else begin
              r_ph <= r_ph + 1'b1;
            end
          end
          S_DATA: begin
            if (r_ph == c_PH_LAST) begin
              r_ph    <= '0;
              r_state <= S_LOW;
              r_dout  <= 1'b0;
            end else begin
              r_ph <= r_ph + 1'b1;
            end
          end
          S_LOW: begin
            if (r_ph == c_PH_LAST) begin
              r_ph <= '0;
              if (r_bit != 5'd0) begin
                r_bit   <= r_bit - 1'b1;
                r_sh    <= {r_sh[22:0], 1'b0};
                r_state <= S_HIGH;
                r_dout  <= 1'b1;
              end else begin
                // Word finished with no follow-on word: latch gap or mid-frame stall
                r_cnt   <= CW'(1);
                r_state <= r_last ? S_GAP : S_IDLE;
                r_busy  <= r_last;
                r_midf  <= ~r_last;
              end
            end else begin
              r_ph <= r_ph + 1'b1;
              if (r_ph == c_PH_PRE && r_bit == 5'd0 && !r_last) r_ready <= 1'b1;
            end
          end
          default: begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trainled_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_trainled_tx
// Purpose  : Randomised self-checking bench for trainled_tx against a
//            waveform-queue reference model and a line decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_trainled_tx;

  localparam int PHASE = 4;
  localparam int GAP   = 128;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [23:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_ready, dout, busy, frame_done, underrun;

  logic [23:0] s_data2  = '0;
  logic        s_valid2 = 1'b0;
  logic        s_last2  = 1'b0;
  logic        s_ready2, dout2, busy2, frame_done2, underrun2;

  trainled_tx #(.PHASE(PHASE), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .dout(dout), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  trainled_tx #(.PHASE(2), .GAP(97)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data2), .s_valid(s_valid2), .s_last(s_last2),
    .s_ready(s_ready2), .dout(dout2), .busy(busy2), .frame_done(frame_done2), .underrun(underrun2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of expected dout values for the word(s) in flight
  logic        q[$];
  int          gap_left, stall;
  logic        midf, cur_last;
  logic [23:0] exp_words[$];
  logic [23:0] dec_q[$];
  logic        prev_dout, dec_active;
  int          dec_age, dec_n;
  logic [23:0] dec_sh;
  int          n_ready, n_fd, n_ur;

  task automatic model_reset();
    q.delete();
    gap_left   = GAP;
    stall      = 0;
    midf       = 1'b0;
    cur_last   = 1'b0;
    exp_words.delete();
    dec_q.delete();
    prev_dout  = 1'b0;
    dec_active = 1'b0;
    dec_age    = 0;
    dec_n      = 0;
    dec_sh     = '0;
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic l, output logic xf);
    logic       er;
    logic [4:0] exp, got;
    @(negedge clk);
    er  = (q.size() > 1) ? 1'b0 : (q.size() == 1) ? ~cur_last : (gap_left == 0);
    exp = {(q.size() > 0) ? q[0] : 1'b0, er, (q.size() > 0) || (gap_left > 0),
           gap_left == 1, midf && (q.size() == 0) && (stall == 96)};
    got = {dout, s_ready, busy, frame_done, underrun};
    check("outputs{dout,ready,busy,done,underrun}", 32'(got), 32'(exp));
    if (s_ready)    n_ready++;
    if (frame_done) n_fd++;
    if (underrun)   n_ur++;
    if (dout && !prev_dout) begin
      dec_active = 1'b1;
      dec_age    = 0;
    end else if (dec_active) begin
      dec_age++;
    end
    if (dec_active && dec_age == PHASE + PHASE / 2) begin
      dec_sh     = {dec_sh[22:0], dout};
      dec_active = 1'b0;
      dec_n++;
      if (dec_n == 24) begin
        dec_q.push_back(dec_sh);
        dec_n = 0;
      end
    end
    prev_dout = dout;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    xf = rst_n && v && er;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0 && !xf) begin
          if (cur_last) gap_left = GAP;
          else begin
            midf  = 1'b1;
            stall = 1;
          end
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else if (midf && !xf) begin
        if (stall == 96) midf = 1'b0;
        else stall++;
      end
      if (xf) begin
        for (int b = 23; b >= 0; b--)
          for (int p = 0; p < 3 * PHASE; p++)
            q.push_back(p < PHASE ? 1'b1 : (p < 2 * PHASE ? d[b] : 1'b0));
        cur_last = l;
        midf     = 1'b0;
        exp_words.push_back(d);
      end
    end
  endtask

  task automatic idle(input int n);
    logic xf;
    repeat (n) step(1'b0, 24'($urandom), 1'($urandom_range(0, 1)), xf);
  endtask

  task automatic send_word(input logic [23:0] d, input logic l);
    logic xf;
    int   k;
    xf = 1'b0;
    k  = 0;
    while (!xf && k < 1000) begin
      step(1'b1, d, l, xf);
      k++;
    end
    check("word_accepted", 32'(xf), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() > 0 && k < 1000) begin
      idle(1);
      k++;
    end
  endtask

  task automatic cmp_words(input string tag);
    check({tag, "_count"}, 32'(dec_q.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < dec_q.size(); i++)
      check({tag, "_word"}, 32'(dec_q[i]), 32'(exp_words[i]));
    exp_words.delete();
    dec_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fd_at, ur_at, k;
    logic [23:0] w;
    logic [3:0]  e2;
    model_reset();
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset release: GAP low cycles, frame_done on the last one, then IDLE
    fd_at = 0;
    for (int i = 1; i <= GAP + 5; i++) begin
      idle(1);
      if (frame_done && fd_at == 0) fd_at = i;
    end
    check("reset_gap_done_cycle", 32'(fd_at), 32'(GAP));
    check("idle_ready", 32'(s_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single word, last=1
    send_word(24'hA50F3C, 1'b1);
    n_fd = 0;
    idle(288 + GAP + 4);
    check("single_done_pulses", 32'(n_fd), 32'd1);
    check("single_nwords", 32'(dec_q.size()), 32'd1);
    if (dec_q.size() > 0) begin
      w = dec_q[0];
      check("led3", 32'(w[23:16]), 32'hA5);
      check("led2", 32'(w[15:8]), 32'h0F);
      check("led1", 32'(w[7:0]), 32'h3C);
    end
    cmp_words("single");

    // Three back-to-back words with s_valid held high
    send_word(24'h123456, 1'b0);
    n_ready = 0;
    send_word(24'hABCDEF, 1'b0);
    send_word(24'h00FF81, 1'b1);
    k = 0;
    while (!frame_done && k < 288 + GAP + 10) begin
      idle(1);
      k++;
    end
    check("chain_boundary_ready_pulses", 32'(n_ready), 32'd2);
    check("chain_nwords", 32'(dec_q.size()), 32'd3);
    if (dec_q.size() == 3) begin
      check("chain_node1", 32'(dec_q[0]), 32'h123456);
      check("chain_node2", 32'(dec_q[1]), 32'hABCDEF);
      check("chain_node3", 32'(dec_q[2]), 32'h00FF81);
    end
    idle(4);
    cmp_words("chain");

    // Mid-frame stall long enough to underrun
    send_word(24'h5A5A5A, 1'b0);
    wait_idle();
    n_ur  = 0;
    ur_at = 0;
    for (int i = 1; i <= 200; i++) begin
      idle(1);
      if (underrun && ur_at == 0) ur_at = i;
    end
    check("underrun_pulses", 32'(n_ur), 32'd1);
    check("underrun_cycle", 32'(ur_at), 32'd96);
    send_word(24'h0F0F0F, 1'b1);
    wait_idle();
    idle(GAP + 5);
    cmp_words("stall");

    // Randomised frames with random gaps, some landing around the 96-clock stall limit
    for (int f = 0; f < 6; f++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) begin
        case ($urandom_range(0, 3))
          0: ;
          1: idle($urandom_range(1, 30));
          2: begin
            wait_idle();
            idle($urandom_range(93, 99));
          end
          default: idle($urandom_range(0, 5));
        endcase
        send_word(24'($urandom), 1'(i == nw - 1));
      end
    end
    wait_idle();
    idle(GAP + 5);
    cmp_words("random");

    // Asynchronous reset in the data phase of bit 10
    send_word(24'hC3A55A, 1'b1);
    idle(13 * 3 * PHASE + PHASE + 1);
    check("pre_reset_dout", 32'(dout), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_dout", 32'(dout), 32'd0);
    check("async_reset_ready", 32'(s_ready), 32'd0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    k = 0;
    while (k < GAP + 20) begin
      idle(1);
      if (s_ready) break;
      k++;
    end
    check("reset_gap_before_ready", 32'(k), 32'(GAP));
    idle(300);
    cmp_words("reset");

    // Minimum configuration: PHASE=2, GAP=97
    @(negedge clk);
    check("min_idle", 32'({busy2, s_ready2}), 32'b01);
    s_valid2 = 1'b1;
    s_data2  = 24'hFFFFFF;
    s_last2  = 1'b1;
    @(negedge clk);
    s_valid2 = 1'b0;
    s_data2  = 24'($urandom);
    for (int i = 1; i <= 144 + 97 + 1; i++) begin
      if (i <= 144)     e2 = {1'(((i - 1) % 6) < 4), 1'b1, 1'b0, 1'b0};
      else if (i <= 241) e2 = {1'b0, 1'b1, 1'b0, 1'(i == 241)};
      else               e2 = 4'b0010;
      check("min_{dout,busy,ready,done}", 32'({dout2, busy2, s_ready2, frame_done2}), 32'(e2));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
